alu_req_driver: RTL and testbench
=================================

Name: alu_req_driver

Overview:
Initiator-side front end for the ALU: accepts one packed operation request over a valid/ready interface and drives the ALU operand/control ports. It waits the command-dependent ALU latency, then captures RES and flags and returns them as a response packet over a second valid/ready interface. It is the hardware counterpart of the bench driver/monitor pair, so system logic and self-test sequencers can exercise the ALU without a testbench. One operation is in flight at a time.

Parameters:
N1, 8, operand width (OPA/OPB)
N2, 4, command width
N3, 16, ALU result width
TAG_W, 8, request tag width (feature ID), echoed on the response
LAT, 1, ALU result latency in clocks for non-multiply commands
MUL_LAT, 2, ALU result latency for MODE=1 with CMD=9 or CMD=10

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  driver can accept a request
req_tag  in  TAG_W  request tag
req_opa, req_opb  in  N1  operands
req_cmd  in  N2  command
req_mode, req_cin  in  1  mode, carry-in
req_in_valid  in  2  operand-valid bits
OPA, OPB  out  N1  to ALU
CMD  out  N2  to ALU
MODE, CIN, CE  out  1  to ALU
IN_VALID  out  2  to ALU
RES  in  N3  from ALU
COUT, OFLOW, G, E, L, ERR  in  1  from ALU
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_tag  out  TAG_W  echoed tag
rsp_res  out  N3  captured RES
rsp_flags  out  6  {COUT,E,L,G,OFLOW,ERR}

Behaviour:
- Reset (async): state=IDLE. All ALU-side outputs, rsp_* and internal counters are 0. req_ready=0 while RST is high.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. Handshake req_valid&&req_ready at edge T0 latches all req_* fields onto the ALU ports and sets CE=1. Next state is ISSUE.
- ISSUE: lasts one cycle. Loads the latency counter with MUL_LAT if MODE=1 and CMD is 9 or 10, else LAT. Next state is WAIT.
- WAIT: counter decrements each edge. On the edge where it reaches 0, RES and the flags are captured into rsp_res/rsp_flags, rsp_valid is set, CE and IN_VALID go to 0, and the state moves to RESP.
- Capture edge = T0+1+latency: T0+2 for non-multiply, T0+3 for multiply. rsp_valid is first high after that edge.
- OPA/OPB/CMD/MODE/CIN/IN_VALID hold stable from T0 until the capture edge.
- RESP: rsp_* are held stable until rsp_ready=1. The edge with rsp_valid&&rsp_ready returns to IDLE. req_ready stays 0 outside IDLE, so back-to-back issue costs at least 3+latency cycles.
- req_valid has no effect outside IDLE. The driver never drops a request it has accepted.
- IN_VALID=00 or an illegal CMD is still issued unchanged. The ALU ERR result is passed through in rsp_flags; the driver raises no error of its own.
- RST asserted mid-operation abandons the operation; no response is produced.

Optional Feature:
ALU_DRV_CHECK_EN:
- When defined, adds these ports: req_exp_res in N3, req_exp_flags in 6, rsp_pass out 1, pass_cnt out 16, fail_cnt out 16.
- Expected values are latched with the request.
- At capture, compare {RES,flags} to the expected value. For non-multiply commands only RES[N1:0] is compared; for multiply (MODE=1, CMD 9/10) all N3 bits are compared. A bit value of X/Z counts as a mismatch.
- rsp_pass is valid alongside rsp_valid. pass_cnt/fail_cnt increment on the response handshake, saturate at 16'hFFFF, and reset to 0.
- When undefined, these ports and the compare logic are absent.

Test Plan:
- ADD: MODE=1, CMD=0, OPA=200, OPB=100, CIN=0, IN_VALID=11, tag=8'h01 -> rsp_valid first high after T0+2; rsp_res=16'h012C; COUT=1 (flags as reference ALU); rsp_tag=8'h01.
- Multiply: MODE=1, CMD=9, OPA=3, OPB=4 -> capture at T0+3; rsp_res=16'd20 ((3+1)*(4+1)); CE low after capture.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid -> rsp_* stable and req_ready=0 throughout; a pending req_valid is accepted only after the response handshake.
- Invalid operands: MODE=1, CMD=0, IN_VALID=00 -> request issued and response returned with ERR bit of rsp_flags =1; state returns to IDLE.
- Reset in WAIT: assert RST one cycle after ISSUE of a CMD=9 request -> all outputs 0 immediately, no rsp_valid; the next request completes normally.
- ALU_DRV_CHECK_EN: run 8 requests with one wrong req_exp_res -> rsp_pass=0 on that response only; final pass_cnt=7, fail_cnt=1.

Source files
------------

// File: rtl/alu_req_driver.sv
// ---------------------------------------------------------------------------
// alu_req_driver
//
// Initiator-side front end for the ALU. Accepts one packed operation request
// on a valid/ready interface, drives the ALU operand/control ports, waits the
// command-dependent ALU latency, captures RES plus flags and returns them with
// the request tag on a second valid/ready interface. One operation in flight.
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   req_valid/ready     request handshake
//   req_tag             request tag, echoed on rsp_tag
//   req_opa/opb/cmd     operands and command
//   req_mode/cin        mode and carry-in
//   req_in_valid        operand-valid bits
//   OPA/OPB/CMD/MODE/CIN/CE/IN_VALID   drive the ALU
//   RES, COUT/OFLOW/G/E/L/ERR          results from the ALU
//   rsp_valid/ready     response handshake
//   rsp_tag/res/flags   echoed tag, captured RES, {COUT,E,L,G,OFLOW,ERR}
//
// Optional feature (macro ALU_DRV_CHECK_EN): adds req_exp_res, req_exp_flags,
// rsp_pass, pass_cnt, fail_cnt. The expected result latched with the request
// is compared against the captured result; saturating pass/fail counters
// advance on each response handshake.
// ---------------------------------------------------------------------------
module alu_req_driver #(
    parameter int N1      = 8,
    parameter int N2      = 4,
    parameter int N3      = 16,
    parameter int TAG_W   = 8,
    parameter int LAT     = 1,
    parameter int MUL_LAT = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [N1-1:0]    req_opa,
    input  logic [N1-1:0]    req_opb,
    input  logic [N2-1:0]    req_cmd,
    input  logic             req_mode,
    input  logic             req_cin,
    input  logic [1:0]       req_in_valid,
`ifdef ALU_DRV_CHECK_EN
    input  logic [N3-1:0]    req_exp_res,
    input  logic [5:0]       req_exp_flags,
    output logic             rsp_pass,
    output logic [15:0]      pass_cnt,
    output logic [15:0]      fail_cnt,
`endif
    output logic [N1-1:0]    OPA,
    output logic [N1-1:0]    OPB,
    output logic [N2-1:0]    CMD,
    output logic             MODE,
    output logic             CIN,
    output logic             CE,
    output logic [1:0]       IN_VALID,
    input  logic [N3-1:0]    RES,
    input  logic             COUT,
    input  logic             OFLOW,
    input  logic             G,
    input  logic             E,
    input  logic             L,
    input  logic             ERR,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [N3-1:0]    rsp_res,
    output logic [5:0]       rsp_flags
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int MAX_LAT = (MUL_LAT > LAT) ? MUL_LAT : LAT;
    localparam int CNT_W   = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT + 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [TAG_W-1:0] tag_hold;
    logic             is_mul;
    logic [5:0]       alu_flags;

    // Multiply detection works off the registered ALU-side copy, which is
    // stable from the accept edge until capture.
    assign is_mul    = MODE && ((CMD == N2'(9)) || (CMD == N2'(10)));
    assign alu_flags = {COUT, E, L, G, OFLOW, ERR};

    // Gate with RST so the interface never advertises readiness while held
    // in reset, even though the state register already reads IDLE.
    always_comb begin
        req_ready = (state == S_IDLE) && !RST;
    end

`ifdef ALU_DRV_CHECK_EN
    // Non-multiply results only carry N1+1 meaningful bits (sum plus carry).
    localparam logic [N3-1:0] LOW_MASK = N3'({(N1 + 1){1'b1}});

    logic [N3-1:0] exp_res_hold;
    logic [5:0]    exp_flags_hold;
    logic [N3-1:0] cmp_mask;
    logic          cmp_pass;

    // An if on an unknown condition takes the else branch in simulation, so
    // X/Z bits inside the compared field resolve to a mismatch.
    always_comb begin
        cmp_mask = is_mul ? '1 : LOW_MASK;
        cmp_pass = 1'b0;
        if ((((RES ^ exp_res_hold) & cmp_mask) == '0) && (alu_flags == exp_flags_hold)) begin
            cmp_pass = 1'b1;
        end
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            cnt       <= '0;
            tag_hold  <= '0;
            OPA       <= '0;
            OPB       <= '0;
            CMD       <= '0;
            MODE      <= 1'b0;
            CIN       <= 1'b0;
            CE        <= 1'b0;
            IN_VALID  <= 2'b00;
            rsp_valid <= 1'b0;
            rsp_tag   <= '0;
            rsp_res   <= '0;
            rsp_flags <= '0;
`ifdef ALU_DRV_CHECK_EN
            exp_res_hold   <= '0;
            exp_flags_hold <= '0;
            rsp_pass       <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        OPA      <= req_opa;
                        OPB      <= req_opb;
                        CMD      <= req_cmd;
                        MODE     <= req_mode;
                        CIN      <= req_cin;
                        IN_VALID <= req_in_valid;
                        CE       <= 1'b1;
                        tag_hold <= req_tag;
`ifdef ALU_DRV_CHECK_EN
                        exp_res_hold   <= req_exp_res;
                        exp_flags_hold <= req_exp_flags;
`endif
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= is_mul ? CNT_W'(MUL_LAT) : CNT_W'(LAT);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // cnt <= 1 means this edge takes it to zero; a zero
                    // latency setting also captures here rather than wrap.
                    if (cnt <= CNT_W'(1)) begin
                        cnt       <= '0;
                        rsp_res   <= RES;
                        rsp_flags <= alu_flags;
                        rsp_tag   <= tag_hold;
                        rsp_valid <= 1'b1;
                        CE        <= 1'b0;
                        IN_VALID  <= 2'b00;
`ifdef ALU_DRV_CHECK_EN
                        rsp_pass  <= cmp_pass;
`endif
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
`ifdef ALU_DRV_CHECK_EN
                        if (rsp_pass) begin
                            if (pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
                        end else begin
                            if (fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
                        end
`endif
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_driver.sv
// ---------------------------------------------------------------------------
// tb_alu_req_driver
//
// Directed bench for alu_req_driver. A small behavioural ALU (one-cycle
// result, two-cycle result for multiplies) sits on the ALU side. Stimulus
// pushes hand-computed expected responses into a scoreboard; a monitor pops
// and compares each time rsp_valid rises. Define ALU_DRV_CHECK_EN to also
// exercise the self-check ports.
// ---------------------------------------------------------------------------
module tb_alu_req_driver;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_tag;
    logic [7:0]  req_opa, req_opb;
    logic [3:0]  req_cmd;
    logic        req_mode, req_cin;
    logic [1:0]  req_in_valid;
    logic [15:0] req_exp_res;
    logic [5:0]  req_exp_flags;
    logic [7:0]  OPA, OPB;
    logic [3:0]  CMD;
    logic        MODE, CIN, CE;
    logic [1:0]  IN_VALID;
    logic [15:0] RES;
    logic        COUT, OFLOW, G, E, L, ERR;
    logic        rsp_valid, rsp_ready;
    logic [7:0]  rsp_tag;
    logic [15:0] rsp_res;
    logic [5:0]  rsp_flags;
`ifdef ALU_DRV_CHECK_EN
    logic        rsp_pass;
    logic [15:0] pass_cnt, fail_cnt;
`endif

    always #5 CLK = ~CLK;

    alu_req_driver dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
        .req_opa(req_opa), .req_opb(req_opb), .req_cmd(req_cmd),
        .req_mode(req_mode), .req_cin(req_cin), .req_in_valid(req_in_valid),
`ifdef ALU_DRV_CHECK_EN
        .req_exp_res(req_exp_res), .req_exp_flags(req_exp_flags),
        .rsp_pass(rsp_pass), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
`endif
        .OPA(OPA), .OPB(OPB), .CMD(CMD), .MODE(MODE), .CIN(CIN), .CE(CE),
        .IN_VALID(IN_VALID), .RES(RES), .COUT(COUT), .OFLOW(OFLOW),
        .G(G), .E(E), .L(L), .ERR(ERR),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
        .rsp_res(rsp_res), .rsp_flags(rsp_flags)
    );

    // ---------------- behavioural ALU ----------------
    function automatic logic [21:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] cmd, input logic mode,
                                          input logic cin, input logic [1:0] iv);
        logic [15:0] r;
        logic [8:0]  s;
        logic [7:0]  a2;
        logic        co, eq, lt, gt, of, er;
        r = '0; s = '0; a2 = '0;
        co = 1'b0; eq = 1'b0; lt = 1'b0; gt = 1'b0; of = 1'b0; er = 1'b0;
        if (iv != 2'b11) begin
            er = 1'b1;
        end else if (mode) begin
            case (cmd)
                4'd0:  begin s = {1'b0, a} + {1'b0, b}; r = {7'd0, s}; co = s[8]; end
                4'd1:  begin r = {8'd0, a - b}; of = (a < b); end
                4'd2:  begin s = {1'b0, a} + {1'b0, b} + {8'd0, cin}; r = {7'd0, s}; co = s[8]; end
                4'd8:  begin eq = (a == b); lt = (a < b); gt = (a > b); end
                4'd9:  r = ({8'd0, a} + 16'd1) * ({8'd0, b} + 16'd1);
                4'd10: begin a2 = a << 1; r = {8'd0, a2} * {8'd0, b}; end
                default: er = 1'b1;
            endcase
        end else begin
            case (cmd)
                4'd0:    r = {8'd0, a & b};
                default: er = 1'b1;
            endcase
        end
        return {co, eq, lt, gt, of, er, r};
    endfunction

    logic [21:0] alu_q  = '0;
    logic [21:0] pipe_q = '0;
    always @(posedge CLK) begin
        if (CE) begin
            pipe_q <= alu_f(OPA, OPB, CMD, MODE, CIN, IN_VALID);
            if (MODE && (CMD == 4'd9 || CMD == 4'd10)) alu_q <= pipe_q;
            else                                      alu_q <= alu_f(OPA, OPB, CMD, MODE, CIN, IN_VALID);
        end
    end
    assign {COUT, E, L, G, OFLOW, ERR, RES} = alu_q;

    // ---------------- bookkeeping ----------------
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    typedef struct {
        logic [7:0]  tag;
        logic [15:0] res;
        logic [5:0]  flags;
        int          at_cyc;
        logic        pass;
    } exp_t;
    exp_t sb[$];

    // ---------------- monitor ----------------
    logic prev_v = 1'b0;
    exp_t mon_e;
    always @(negedge CLK) begin
        if (!RST && rsp_valid && !prev_v) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_tag), 32'hFFFF_FFFF);
            end else begin
                mon_e = sb.pop_front();
                $display("rsp tag=%02h res=%04h flags=%06b cycle=%0d", rsp_tag, rsp_res, rsp_flags, cyc);
                check("rsp_tag",   32'(rsp_tag),   32'(mon_e.tag));
                check("rsp_res",   32'(rsp_res),   32'(mon_e.res));
                check("rsp_flags", 32'(rsp_flags), 32'(mon_e.flags));
                check("rsp_cycle", 32'(cyc),       32'(mon_e.at_cyc));
                check("ce_low",    32'({CE, IN_VALID}), 32'd0);
`ifdef ALU_DRV_CHECK_EN
                check("rsp_pass",  32'(rsp_pass),  32'(mon_e.pass));
`endif
            end
        end
        prev_v = rsp_valid;
    end

    // ---------------- stimulus ----------------
    // Called at a negedge. Holds req_valid until accepted, then returns at the
    // negedge following the accept edge T0.
    task automatic issue(input logic [7:0] tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] cmd, input logic mode, input logic cin,
                         input logic [1:0] iv, input logic [15:0] xres, input logic [5:0] xflags,
                         input logic track, input logic [15:0] off);
        int  lat;
        bit  done;
        req_tag = tag; req_opa = a; req_opb = b; req_cmd = cmd;
        req_mode = mode; req_cin = cin; req_in_valid = iv;
        req_exp_res = xres + off; req_exp_flags = xflags;
        req_valid = 1'b1;
        lat  = (mode && (cmd == 4'd9 || cmd == 4'd10)) ? 2 : 1;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (req_ready) begin
                // Accept edge T0 = cyc+1; response first visible after T0+1+lat.
                if (track) sb.push_back('{tag, xres, xflags, cyc + 2 + lat, (off == 16'd0)});
                @(posedge CLK);
                @(negedge CLK);
                req_valid = 1'b0;
                done = 1'b1;
            end else begin
                @(negedge CLK);
            end
        end
        if (!done) begin
            check("issue_timeout", 32'd1, 32'd0);
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (sb.size() != 0 || rsp_valid); i++) @(negedge CLK);
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    logic [29:0] snap;

    initial begin
        RST = 1'b1; req_valid = 1'b0; req_tag = '0; req_opa = '0; req_opb = '0;
        req_cmd = '0; req_mode = 1'b0; req_cin = 1'b0; req_in_valid = 2'b00;
        req_exp_res = '0; req_exp_flags = '0; rsp_ready = 1'b1;
        repeat (2) @(negedge CLK);

        // Reset state
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_alu_ops",   32'({OPA, OPB}), 32'd0);
        check("rst_alu_ctl",   32'({CMD, MODE, CIN, CE, IN_VALID}), 32'd0);
        check("rst_rsp",       32'({rsp_valid, rsp_tag, rsp_flags}), 32'd0);
        check("rst_rsp_res",   32'(rsp_res), 32'd0);
        RST = 1'b0;
        #1;
        check("idle_req_ready", 32'(req_ready), 32'd1);
        @(negedge CLK);

        // Directed operations
        issue(8'h01, 8'd200, 8'd100, 4'd0,  1'b1, 1'b0, 2'b11, 16'h012C, 6'b100000, 1'b1, 16'd0);
        issue(8'h02, 8'd3,   8'd4,   4'd9,  1'b1, 1'b0, 2'b11, 16'd20,   6'b000000, 1'b1, 16'd0);
        issue(8'h03, 8'd10,  8'd3,   4'd1,  1'b1, 1'b0, 2'b11, 16'd7,    6'b000000, 1'b1, 16'd0);
        issue(8'h04, 8'hF0,  8'h3C,  4'd0,  1'b0, 1'b0, 2'b11, 16'h0030, 6'b000000, 1'b1, 16'd0);
        issue(8'h05, 8'd5,   8'd9,   4'd8,  1'b1, 1'b0, 2'b11, 16'd0,    6'b001000, 1'b1, 16'd0);
        issue(8'h06, 8'd5,   8'd6,   4'd10, 1'b1, 1'b0, 2'b11, 16'd60,   6'b000000, 1'b1, 16'd0);
        issue(8'h07, 8'd100, 8'd27,  4'd2,  1'b1, 1'b1, 2'b11, 16'h0080, 6'b000000, 1'b1, 16'd0);
        issue(8'h08, 8'd1,   8'd2,   4'd15, 1'b1, 1'b0, 2'b11, 16'd0,    6'b000001, 1'b1, 16'd0);
        issue(8'h09, 8'd200, 8'd100, 4'd0,  1'b1, 1'b0, 2'b00, 16'd0,    6'b000001, 1'b1, 16'd0);
        drain();
        check("idle_after_err", 32'(req_ready), 32'd1);

        // Backpressure with a pending request behind it
        rsp_ready = 1'b0;
        issue(8'h0A, 8'd1, 8'd2, 4'd0, 1'b1, 1'b0, 2'b11, 16'd3, 6'b000000, 1'b1, 16'd0);
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge CLK);
        check("bp_rsp_seen", 32'(rsp_valid), 32'd1);
        snap = {rsp_tag, rsp_res, rsp_flags};
        fork
            issue(8'h0B, 8'd7, 8'd8, 4'd0, 1'b1, 1'b0, 2'b11, 16'd15, 6'b000000, 1'b1, 16'd0);
            begin
                for (int i = 0; i < 10; i++) begin
                    check("bp_hold", 32'({rsp_valid, req_ready, snap == {rsp_tag, rsp_res, rsp_flags}}), 32'b101);
                    @(negedge CLK);
                end
                rsp_ready = 1'b1;
            end
        join
        drain();

        // Reset while waiting on a multiply
        issue(8'h0C, 8'd6, 8'd6, 4'd9, 1'b1, 1'b0, 2'b11, 16'd49, 6'b000000, 1'b0, 16'd0);
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        check("mid_rst_alu", 32'({OPA, OPB, CMD, MODE, CIN, CE, IN_VALID}), 32'd0);
        check("mid_rst_rsp", 32'({rsp_valid, req_ready, rsp_tag, rsp_flags}), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        repeat (5) @(negedge CLK);
        check("post_rst_quiet", 32'({rsp_valid, req_ready}), 32'b01);
        issue(8'h0D, 8'd2, 8'd2, 4'd9, 1'b1, 1'b0, 2'b11, 16'd9, 6'b000000, 1'b1, 16'd0);
        drain();

`ifdef ALU_DRV_CHECK_EN
        // Self-check: eight requests, tag 0x23 carries a wrong expectation
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            issue(8'(8'h20 + i), 8'(i), 8'(i), 4'd0, 1'b1, 1'b0, 2'b11, 16'(2 * i), 6'b000000,
                  1'b1, (i == 3) ? 16'd1 : 16'd0);
        end
        drain();
        check("pass_cnt", 32'(pass_cnt), 32'd7);
        check("fail_cnt", 32'(fail_cnt), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
